// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types and helpers for the sliced ALU sequencer.
//   opsel_e       : operation select encoding.
//   state_e       : sequencer control states.
//   init_carry    : carry fed into the least-significant slice.
//   force_carry_0 : the operation suppresses every carry (PASS).
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_ADDNOT  = 3'b001,
      OP_PASS    = 3'b010,
      OP_SUB     = 3'b011,
      OP_INC     = 3'b100,
      OP_DEC     = 3'b101,
      OP_ADDINC  = 3'b110,
      OP_ILLEGAL = 3'b111
   } opsel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic init_carry(input opsel_e op);
      return (op == OP_SUB) || (op == OP_INC) || (op == OP_ADDINC);
   endfunction

   function automatic logic force_carry_0(input opsel_e op);
      return (op == OP_PASS);
   endfunction

endpackage

// File: rtl/arith_slice.sv
// arith_slice
//   Combinational SLICE_W-bit ripple adder with per-operation B selection.
//   a_slice  : operand A bits of this slice.
//   b_slice  : raw operand B bits of this slice.
//   cin      : carry into the slice LSB.
//   opsel    : operation select.
//   sum      : slice result.
//   cout     : carry out of the slice MSB.
//   c_msb_in : carry into the slice MSB (for signed overflow).
module arith_slice
   import alu_seq_pkg::*;
#(
   parameter int unsigned SLICE_W = 32
) (
   input  logic [SLICE_W-1:0] a_slice,
   input  logic [SLICE_W-1:0] b_slice,
   input  logic               cin,
   input  opsel_e             opsel,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               c_msb_in
);

   logic [SLICE_W-1:0] b_eff;
   logic               kill;
   logic               c;

   always_comb begin
      b_eff = '0;
      case (opsel)
         OP_ADD, OP_ADDINC: b_eff = b_slice;
         OP_ADDNOT, OP_SUB: b_eff = ~b_slice;
         OP_DEC:            b_eff = '1;
         default:           b_eff = '0;
      endcase
   end

   // PASS forces every carry to zero, so the chain degenerates to sum = A.
   always_comb begin
      kill     = force_carry_0(opsel);
      sum      = '0;
      c_msb_in = 1'b0;
      c        = cin & ~kill;
      for (int unsigned i = 0; i < SLICE_W; i++) begin
         if (i == SLICE_W - 1) c_msb_in = c;
         sum[i] = a_slice[i] ^ b_eff[i] ^ c;
         c      = ((a_slice[i] & b_eff[i]) | (c & (a_slice[i] ^ b_eff[i]))) & ~kill;
      end
      cout = c;
   end

endmodule

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//   Computes a WIDTH-bit arithmetic op by running one SLICE_W-bit slice over
//   WIDTH/SLICE_W cycles, LSB slice first, carry held in a register.
//   clk, rst_n             : clock (rising edge), async active-low reset.
//   req_valid/req_ready    : request handshake; req_opsel, req_a, req_b payload.
//   rsp_valid/rsp_ready    : response handshake.
//   rsp_result, rsp_cout,
//   rsp_ovf, rsp_err       : result, MSB carry, signed overflow, illegal op.
module alu_slice_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = 128,
   parameter int unsigned SLICE_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_opsel,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             rsp_err
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   opsel_e             op_q, op_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic [SLICE_W-1:0] s_sum;
   logic               s_cout;
   logic               s_cmsb;
   opsel_e             req_op;

   assign req_op = opsel_e'(req_opsel);

   arith_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a_slice  (a_q[idx_q*SLICE_W +: SLICE_W]),
      .b_slice  (b_q[idx_q*SLICE_W +: SLICE_W]),
      .cin      (carry_q),
      .opsel    (op_q),
      .sum      (s_sum),
      .cout     (s_cout),
      .c_msb_in (s_cmsb)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d      = req_a;
               b_d      = req_b;
               op_d     = req_op;
               idx_d    = '0;
               carry_d  = init_carry(req_op);
               result_d = '0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               err_d    = (req_op == OP_ILLEGAL);
               state_d  = (req_op == OP_ILLEGAL) ? DONE : RUN;
            end
         end
         RUN: begin
            result_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
            carry_d = s_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = s_cout;
               ovf_d   = s_cmsb ^ s_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   // Gated by rst_n so the front-end sees not-ready for the whole reset window.
   assign req_ready  = rst_n && (state_q == IDLE);
   assign rsp_valid  = (state_q == DONE);
   assign rsp_result = result_q;
   assign rsp_cout   = cout_q;
   assign rsp_ovf    = ovf_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
module tb_alu_slice_sequencer;

   localparam int unsigned W = 128;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_opsel;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_cout;
   logic         rsp_ovf;
   logic         rsp_err;

   int total = 0;
   int bad   = 0;

   localparam logic [W-1:0] ONES = '1;
   localparam logic [W-1:0] MSB1 = {1'b1, {(W-1){1'b0}}};

   alu_slice_sequencer #(.WIDTH(128), .SLICE_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opsel  (req_opsel),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge, hold until accepted, return edges from
   // accept edge to rsp_valid (legal ops: 4, illegal: 0).
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag, output int lat);
      int guard = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_opsel = op;
      req_a     = a;
      req_b     = b;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_ready"}, W'(req_ready), W'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = ONES;
      req_b     = ONES;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, "_vld_drop"}, W'(rsp_valid), W'(0));
      check({tag, "_rdy_back"}, W'(req_ready), W'(1));
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input logic ee, input int elat, input string tag);
      int lat;
      issue(op, a, b, tag, lat);
      check({tag, "_lat"}, W'(lat), W'(elat));
      check({tag, "_res"}, rsp_result, er);
      check({tag, "_cout"}, W'(rsp_cout), W'(ec));
      check({tag, "_ovf"}, W'(rsp_ovf), W'(eo));
      check({tag, "_err"}, W'(rsp_err), W'(ee));
      handshake(tag);
   endtask

   initial begin
      int lat;
      int seen;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_opsel = 3'b000;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #12;
      check("rst_ready", W'(req_ready), W'(0));
      check("rst_valid", W'(rsp_valid), W'(0));
      check("rst_result", rsp_result, '0);
      check("rst_flags", W'({rsp_cout, rsp_ovf, rsp_err}), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ready", W'(req_ready), W'(1));

      run_op(3'b000, 128'h0000_0000_FFFF_FFFF, 128'h1, 128'h1_0000_0000, 0, 0, 0, 4, "add_xslice");
      run_op(3'b011, '0, 128'h1, ONES, 0, 0, 0, 4, "sub_0m1");
      run_op(3'b011, 128'h5, 128'h5, '0, 1, 0, 0, 4, "sub_5m5");
      run_op(3'b011, MSB1, 128'h1, ~MSB1, 1, 1, 0, 4, "sub_ovf");
      run_op(3'b100, ONES, 128'h0, '0, 1, 0, 0, 4, "inc_wrap");
      run_op(3'b101, '0, 128'h0, ONES, 0, 0, 0, 4, "dec_0");
      run_op(3'b010, 128'hDEAD_BEEF, ONES, 128'hDEAD_BEEF, 0, 0, 0, 4, "pass");
      run_op(3'b001, 128'h5, 128'h0, 128'h4, 1, 0, 0, 4, "addnot");
      run_op(3'b110, 128'h1, 128'h2, 128'h4, 0, 0, 0, 4, "addinc");
      run_op(3'b000, ~MSB1, 128'h1, MSB1, 0, 1, 0, 4, "add_ovf");
      run_op(3'b111, 128'h1234, 128'h5678, '0, 0, 0, 1, 0, "illegal");
      run_op(3'b000, 128'h3, 128'h4, 128'h7, 0, 0, 0, 4, "after_ill");

      // Backpressure with a queued request waiting behind the response.
      issue(3'b000, 128'd10, 128'd20, "bp", lat);
      check("bp_lat", W'(lat), W'(4));
      @(negedge clk);
      req_valid = 1'b1;
      req_opsel = 3'b000;
      req_a     = 128'd1;
      req_b     = 128'd1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", W'(rsp_valid), W'(1));
         check("bp_result", rsp_result, 128'd30);
         check("bp_ready", W'(req_ready), W'(0));
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("bp_vld_drop", W'(rsp_valid), W'(0));
      check("bp_rdy_back", W'(req_ready), W'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("q_accepted", W'(req_ready), W'(0));
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("q_lat", W'(lat), W'(4));
      check("q_result", rsp_result, 128'd2);
      handshake("q");

      // Reset during RUN slice 2: abort with no response.
      @(negedge clk);
      req_valid = 1'b1;
      req_opsel = 3'b000;
      req_a     = ONES;
      req_b     = 128'h1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", W'(req_ready), W'(0));
      check("mid_rst_valid", W'(rsp_valid), W'(0));
      check("mid_rst_result", rsp_result, '0);
      check("mid_rst_flags", W'({rsp_cout, rsp_ovf, rsp_err}), W'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_rel_ready", W'(req_ready), W'(1));
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen++;
      end
      check("no_rsp_after_abort", W'(seen), W'(0));
      run_op(3'b000, 128'h3, 128'h4, 128'h7, 0, 0, 0, 4, "post_rst_add");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit arithmetic operation by running one SLICE_W-bit arithmetic slice over NSLICE = WIDTH/SLICE_W cycles.
- Processes the least-significant slice first and carries between slices through a state register.
- Sits between the ALU front-end (request/response handshake) and a narrow arithmetic datapath. It trades latency for area against the flat 128-bit ripple chain.

Parameters:
- WIDTH, 128, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 32, bits processed per cycle; NSLICE = WIDTH/SLICE_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_opsel  in  3  operation select.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  result.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ovf  out  1  signed overflow (carry into MSB xor carry out).
- rsp_err  out  1  illegal opsel.

Behaviour:
- Opsel encoding. Each op gives the per-bit B operand and the initial carry:
  - 000 ADD: B, c0=0
  - 001 ADDNOT: ~B, c0=0
  - 010 PASS: 0, carry forced 0 on every bit
  - 011 SUB: ~B, c0=1
  - 100 INC: 0, c0=1
  - 101 DEC: all-ones, c0=0
  - 110 ADDINC: B, c0=1
  - 111 illegal
- PASS result = A, cout=0, ovf=0.
- States are IDLE, RUN and DONE.
- Reset, asynchronous while rst_n is low:
  - state=IDLE.
  - req_ready=0 while rst_n is low, 1 in the first IDLE cycle after release.
  - rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_ovf=0, rsp_err=0.
  - Slice index=0, carry register=0, operand registers=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch A, B and opsel, set index=0, and load carry=c0.
  - Legal opsel: go to RUN.
  - 111: go to DONE with result=0, cout=0, ovf=0, err=1 (response valid 1 cycle after accept).
- RUN:
  - req_ready=0.
  - Each cycle, slice index k computes bits [k*SLICE_W +: SLICE_W] from latched A, the op-selected B and the carry register.
  - The result slice is written into the result register and the carry register takes the slice carry out.
  - On k=NSLICE-1, also capture cout and ovf (ovf from the slice's MSB carry-in/out) and go to DONE.
  - Otherwise increment k.
- Latency: rsp_valid rises exactly NSLICE cycles after the accepting edge (4 for defaults).
- DONE:
  - rsp_valid=1; rsp_* outputs stable until handshake.
  - On rsp_ready, go to IDLE next cycle with rsp_valid=0.
  - req_ready stays 0 in DONE, so back-to-back throughput is one op per NSLICE+2 cycles.
- req_* changes while not ready are ignored; operands are latched only at acceptance.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-RUN or in DONE aborts the operation with no response and returns all outputs to reset values.
- Arithmetic: all sums are modulo 2^WIDTH; no sign extension.

Decomposition:
- Package alu_seq_pkg holds:
  - opsel_e enum (OP_ADD..OP_ILLEGAL)
  - state_e enum (IDLE, RUN, DONE)
  - function returning the initial carry per opsel
  - function returning a force-carry-zero flag for PASS
- Sub-module arith_slice: combinational SLICE_W-bit block.
  - Inputs: a_slice, b_slice, cin, opsel.
  - Outputs: sum, cout, c_msb_in (carry into the slice MSB).
  - It applies the per-bit B/carry selection from the encoding above and a ripple chain.

Test Plan (defaults WIDTH=128, SLICE_W=32):
- ADD A=0x0000_0000_FFFF_FFFF, B=1 -> result 0x1_0000_0000, cout=0, ovf=0; rsp_valid exactly 4 cycles after accept (carry crosses slice boundary).
- SUB A=0, B=1 -> result all-ones, cout=0. SUB A=5, B=5 -> result 0, cout=1. SUB A=0x8000...0, B=1 -> 0x7FFF...F, ovf=1.
- INC A=all-ones -> 0, cout=1. DEC A=0 -> all-ones, cout=0. PASS A=0xDEAD_BEEF, B=all-ones -> 0xDEAD_BEEF, cout=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_* stable, req_ready=0; after the handshake, req_ready=1 next cycle and a queued req is accepted.
- opsel=111 -> rsp_valid 1 cycle after accept, rsp_err=1, result=0; the following legal op has err=0.
- Assert rst_n=0 during RUN slice 2 -> all outputs immediately at reset values, no response emitted. After release, ADD 3+4 -> 7, correct latency.
